// File: rtl/sprite_scan_if.sv
// OAM read port and sprite-store write port of the line scan, bundled as one bus.
interface sprite_scan_if;
  logic       oam_rd;
  logic [7:0] oam_addr;
  logic [7:0] oam_y;
  logic       store_clear;
  logic       store_we;
  logic [3:0] store_slot;
  logic [5:0] store_index;
  logic [3:0] store_line;

  // Scan writer side: issues OAM reads, writes the sprite store.
  modport master (
    output oam_rd,
    output oam_addr,
    input  oam_y,
    output store_clear,
    output store_we,
    output store_slot,
    output store_index,
    output store_line
  );

  // OAM / store side.
  modport slave (
    input  oam_rd,
    input  oam_addr,
    output oam_y,
    input  store_clear,
    input  store_we,
    input  store_slot,
    input  store_index,
    input  store_line
  );
endinterface

// File: rtl/sprite_scan_writer.sv
// Per-line OAM scan: reads every entry's Y byte, tests it against the current
// line and writes the first MaxSprites hits into consecutive sprite-store slots.
module sprite_scan_writer #(
  parameter int unsigned NumOam     = 40,
  parameter int unsigned MaxSprites = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_start,
  input  logic [7:0]           ly,
  input  logic                 tall,
  sprite_scan_if.master        bus,
  output logic [3:0]           sprite_count,
  output logic                 scan_busy,
  output logic                 scan_done
);

  typedef enum logic [1:0] {StIdle, StRead, StCmp, StDone} state_e;

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] count_q, count_d;

  logic [8:0] diff;
  logic       hit;

  // Row offset of this line inside the sprite; wraps modulo 512 so sprites
  // below the line land far out of range.
  assign diff = {1'b0, ly} + 9'd16 - {1'b0, bus.oam_y};
  assign hit  = diff < (tall ? 9'd16 : 9'd8);

  // State, entry index and hit count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 6'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and Mealy outputs.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    count_d         = count_q;
    bus.oam_rd      = 1'b0;
    bus.oam_addr    = 8'd0;
    bus.store_clear = 1'b0;
    bus.store_we    = 1'b0;
    bus.store_slot  = 4'd0;
    bus.store_index = 6'd0;
    bus.store_line  = 4'd0;
    scan_done       = 1'b0;

    unique case (state_q)
      StIdle: ;
      StRead: begin
        bus.oam_rd   = 1'b1;
        bus.oam_addr = {idx_q, 2'b00};
        // idx 0 is read exactly once per scan, so it marks the scan's first cycle.
        bus.store_clear = (idx_q == 6'd0);
        state_d = StCmp;
      end
      StCmp: begin
        if (hit && (count_q < 4'(MaxSprites))) begin
          bus.store_we    = 1'b1;
          bus.store_slot  = count_q;
          bus.store_index = idx_q;
          bus.store_line  = diff[3:0];
          count_d         = count_q + 4'd1;
        end
        if (idx_q == 6'(NumOam - 1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = StRead;
        end
      end
      StDone: begin
        scan_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A start pulse restarts from any state; a CMP write this cycle still stands.
    if (scan_start) begin
      state_d = StRead;
      idx_d   = 6'd0;
      count_d = 4'd0;
    end
  end

  assign sprite_count = count_q;
  assign scan_busy    = (state_q == StRead) || (state_q == StCmp);

endmodule

// File: tb/tb_sprite_scan_writer.sv
// Directed bench for sprite_scan_writer with a behavioural OAM and a write log.
module tb_sprite_scan_writer;
  logic       clk = 1'b0;
  logic       reset;
  logic       scan_start;
  logic [7:0] ly;
  logic       tall;
  logic [3:0] sprite_count;
  logic       scan_busy;
  logic       scan_done;

  sprite_scan_if bus ();

  sprite_scan_writer dut (
    .clk          (clk),
    .reset        (reset),
    .scan_start   (scan_start),
    .ly           (ly),
    .tall         (tall),
    .bus          (bus),
    .sprite_count (sprite_count),
    .scan_busy    (scan_busy),
    .scan_done    (scan_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // OAM Y bytes; data appears the cycle after the read strobe.
  logic [7:0] oam_mem [0:63];
  always @(posedge clk) begin
    if (bus.oam_rd) bus.oam_y <= oam_mem[bus.oam_addr[7:2]];
  end

  // Cycle number within the scan: the cycle after start is sampled is cycle 1.
  int cyc = 0;
  always @(posedge clk) cyc <= scan_start ? 1 : cyc + 1;

  // Event log, sampled on the falling edge.
  logic       log_clr = 1'b0;
  int         wr_cnt, clr_cnt, clr_cyc, done_cnt, done_cyc, busy_cnt;
  int         wr_cyc   [0:31];
  logic [3:0] wr_slot  [0:31];
  logic [5:0] wr_index [0:31];
  logic [3:0] wr_line  [0:31];
  logic [7:0] last_addr;
  always @(negedge clk) begin
    if (log_clr) begin
      wr_cnt = 0; clr_cnt = 0; clr_cyc = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0;
      last_addr = 8'd0;
    end else begin
      if (bus.store_we && wr_cnt < 32) begin
        wr_cyc[wr_cnt]   = cyc;
        wr_slot[wr_cnt]  = bus.store_slot;
        wr_index[wr_cnt] = bus.store_index;
        wr_line[wr_cnt]  = bus.store_line;
        wr_cnt++;
      end
      if (bus.store_clear) begin clr_cnt++; clr_cyc = cyc; end
      if (scan_done) begin done_cnt++; done_cyc = cyc; end
      if (scan_busy) busy_cnt++;
      if (bus.oam_rd) last_addr = bus.oam_addr;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " oam_rd"}, int'(bus.oam_rd), 0);
    chk({tag, " store_clear"}, int'(bus.store_clear), 0);
    chk({tag, " store_we"}, int'(bus.store_we), 0);
    chk({tag, " count"}, int'(sprite_count), 0);
    chk({tag, " busy"}, int'(scan_busy), 0);
    chk({tag, " done"}, int'(scan_done), 0);
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    @(negedge clk);
    #1 log_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 scan_start = 1'b1;
    @(posedge clk);
    #1 scan_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, " done seen"}, done_cnt, 1);
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc != c && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("wait cycle", cyc, c);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) oam_mem[i] = v;
  endtask

  initial begin
    reset = 1'b1; scan_start = 1'b0; ly = 8'd0; tall = 1'b0;
    fill(8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    #1 reset = 1'b0;

    // 1) all Y=0: no hits, full-length scan
    clear_log(); pulse_start(); wait_done("t1");
    chk("t1 writes", wr_cnt, 0);
    chk("t1 done cyc", done_cyc, 81);
    chk("t1 count", int'(sprite_count), 0);
    chk("t1 clear cnt", clr_cnt, 1);
    chk("t1 clear cyc", clr_cyc, 1);
    chk("t1 busy cycles", busy_cnt, 80);
    chk("t1 last addr", int'(last_addr), 156);

    // 2) single hit on entry 5
    ly = 8'd10; oam_mem[5] = 8'd20;
    clear_log(); pulse_start(); wait_done("t2");
    chk("t2 writes", wr_cnt, 1);
    chk("t2 cyc", wr_cyc[0], 12);
    chk("t2 slot", int'(wr_slot[0]), 0);
    chk("t2 index", int'(wr_index[0]), 5);
    chk("t2 line", int'(wr_line[0]), 6);
    chk("t2 count", int'(sprite_count), 1);

    // 3) every entry hits; store saturates at 10
    fill(8'd26);
    clear_log(); pulse_start(); wait_done("t3");
    chk("t3 writes", wr_cnt, 10);
    chk("t3 slot9", int'(wr_slot[9]), 9);
    chk("t3 index9", int'(wr_index[9]), 9);
    chk("t3 line9", int'(wr_line[9]), 0);
    chk("t3 cyc9", wr_cyc[9], 20);
    chk("t3 count", int'(sprite_count), 10);
    chk("t3 done cyc", done_cyc, 81);

    // 4) height boundary
    fill(8'd0); ly = 8'd5; tall = 1'b0; oam_mem[3] = 8'd14;
    clear_log(); pulse_start(); wait_done("t4a");
    chk("t4a writes", wr_cnt, 1);
    chk("t4a line", int'(wr_line[0]), 7);
    chk("t4a cyc", wr_cyc[0], 8);
    oam_mem[3] = 8'd13;
    clear_log(); pulse_start(); wait_done("t4b");
    chk("t4b writes", wr_cnt, 0);
    tall = 1'b1;
    clear_log(); pulse_start(); wait_done("t4c");
    chk("t4c writes", wr_cnt, 1);
    chk("t4c index", int'(wr_index[0]), 3);
    chk("t4c line", int'(wr_line[0]), 8);

    // 5) diff 0 hits, diff wrapping to 511 misses
    fill(8'd0); ly = 8'd0; oam_mem[0] = 8'd16; oam_mem[1] = 8'd17;
    clear_log(); pulse_start(); wait_done("t5");
    chk("t5 writes", wr_cnt, 1);
    chk("t5 index", int'(wr_index[0]), 0);
    chk("t5 line", int'(wr_line[0]), 0);

    // 6a) restart during cycle 40
    fill(8'd26); ly = 8'd10; tall = 1'b0;
    clear_log(); pulse_start(); wait_cyc(40);
    scan_start = 1'b1;
    @(posedge clk);
    #1 scan_start = 1'b0;
    @(negedge clk);
    chk("t6 restart clear", int'(bus.store_clear), 1);
    chk("t6 restart addr", int'(bus.oam_addr), 0);
    chk("t6 restart count", int'(sprite_count), 0);
    wait_done("t6");
    chk("t6 clear cnt", clr_cnt, 2);
    chk("t6 done cyc", done_cyc, 81);
    chk("t6 writes", wr_cnt, 20);
    chk("t6 rescan slot", int'(wr_slot[10]), 0);
    chk("t6 rescan cyc", wr_cyc[10], 2);
    chk("t6 count", int'(sprite_count), 10);

    // 6b) reset at cycle 30 aborts before the later hits
    fill(8'd0); oam_mem[20] = 8'd26; oam_mem[30] = 8'd26;
    clear_log(); pulse_start(); wait_cyc(30);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_quiet("t6 reset");
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("t6 reset writes", wr_cnt, 0);
    chk("t6 reset done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
